// File: rtl/sr_pulse_gen.sv
// Button conditioning for sr_latch: per-channel 2-flop sync + counter debounce, rise-edge pulses, s/r arbiter.
// Optional macro SR_RESET_PRIORITY_EN: on a simultaneous set/reset edge, reset wins instead of both being dropped.
module sr_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic s_btn,
    input  logic r_btn,
    output logic s,
    output logic r,
    output logic s_db,
    output logic r_db,
    output logic conflict
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the set channel, index 1 the reset channel.
    logic [1:0]    btn;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    level;
    logic [1:0]    accept;
    logic [1:0]    rise;
    logic [CW-1:0] cnt [2];

    assign btn  = {r_btn, s_btn};
    assign s_db = level[0];
    assign r_db = level[1];

    // A rise is flagged on the same edge that commits the new level, so the pulse lines up with s_db/r_db.
    always_comb begin
        accept = '0;
        rise   = '0;
        for (int i = 0; i < 2; i++) begin
            accept[i] = (sync2[i] != level[i]) && (cnt[i] == CNT_MAX);
            rise[i]   = accept[i] && sync2[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            level    <= '0;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end

            if (rise[0] && rise[1]) begin
                conflict <= 1'b1;
`ifdef SR_RESET_PRIORITY_EN
                s <= 1'b0;
                r <= 1'b1;
`else
                s <= 1'b0;
                r <= 1'b0;
`endif
            end else begin
                conflict <= 1'b0;
                s        <= rise[0];
                r        <= rise[1];
            end
        end
    end
endmodule

// File: tb/tb_sr_pulse_gen.sv
// Scoreboard bench for sr_pulse_gen: stimulus queues expected pulses by edge number, a monitor checks every pulse.
module tb_sr_pulse_gen;
    localparam int DC = 4;
`ifdef SR_RESET_PRIORITY_EN
    localparam logic PRIO_R = 1'b1;
`else
    localparam logic PRIO_R = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_btn = 1'b0;
    logic r_btn = 1'b0;
    logic s, r, s_db, r_db, conflict;

    typedef struct {
        int   cyc;
        logic s;
        logic r;
        logic c;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   tests = 0;
    int   fails = 0;
    int   n;
    int   m;
    int   n2;
    logic bounce [5];

    sr_pulse_gen #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk),
        .rst(rst),
        .s_btn(s_btn),
        .r_btn(r_btn),
        .s(s),
        .r(r),
        .s_db(s_db),
        .r_db(r_db),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: numbers every rising edge and matches any pulse against the head of the scoreboard.
    always @(posedge clk) begin
        #1;
        edge_cnt++;
        while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
            tests++;
            fails++;
            $display("[TB] FAIL missed_pulse: got no pulse, expected s=%b r=%b conflict=%b at edge %0d",
                     sb[0].s, sb[0].r, sb[0].c, sb[0].cyc);
            sb.delete(0);
        end
        if (s || r || conflict) begin
            tests++;
            if (sb.size() == 0 || sb[0].cyc != edge_cnt) begin
                fails++;
                $display("[TB] FAIL unexpected_pulse: got s=%b r=%b conflict=%b at edge %0d, expected none",
                         s, r, conflict, edge_cnt);
            end else begin
                if ({s, r, conflict} !== {sb[0].s, sb[0].r, sb[0].c}) begin
                    fails++;
                    $display("[TB] FAIL pulse_value: got s=%b r=%b conflict=%b, expected s=%b r=%b conflict=%b at edge %0d",
                             s, r, conflict, sb[0].s, sb[0].r, sb[0].c, edge_cnt);
                end
                sb.delete(0);
            end
        end
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b, expected %b (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Drives both buttons (call at a negedge) and returns the edge that will first sample them.
    task automatic applyStimulus(input logic sv, input logic rv, output int first_edge);
        s_btn      = sv;
        r_btn      = rv;
        first_edge = edge_cnt + 1;
    endtask

    task automatic expectPulse(input int cyc, input logic es, input logic er, input logic ec);
        exp_t e;
        e.cyc = cyc;
        e.s   = es;
        e.r   = er;
        e.c   = ec;
        sb.push_back(e);
    endtask

    task automatic waitUntil(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    initial begin
        bounce[0] = 1'b1; bounce[1] = 1'b0; bounce[2] = 1'b1; bounce[3] = 1'b1; bounce[4] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_s", s, 1'b0);
        checkOutput("reset_r", r, 1'b0);
        checkOutput("reset_s_db", s_db, 1'b0);
        checkOutput("reset_r_db", r_db, 1'b0);
        checkOutput("reset_conflict", conflict, 1'b0);
        rst = 1'b0;

        // Clean set
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, n);
        expectPulse(n + 5, 1'b1, 1'b0, 1'b0);
        waitUntil(n + 4);
        checkOutput("clean_s_db_early", s_db, 1'b0);
        waitUntil(n + 5);
        checkOutput("clean_s_db_rise", s_db, 1'b1);
        checkOutput("clean_s_pulse", s, 1'b1);
        waitUntil(n + 6);
        checkOutput("clean_s_low", s, 1'b0);
        checkOutput("clean_s_db_hold", s_db, 1'b1);

        // Release then repress
        applyStimulus(1'b0, 1'b0, n);
        waitUntil(n + 4);
        checkOutput("release_s_db_early", s_db, 1'b1);
        waitUntil(n + 5);
        checkOutput("release_s_db_fall", s_db, 1'b0);
        waitUntil(n + 7);
        applyStimulus(1'b1, 1'b0, n);
        expectPulse(n + 5, 1'b1, 1'b0, 1'b0);
        waitUntil(n + 4);
        checkOutput("repress_s_db_early", s_db, 1'b0);
        waitUntil(n + 5);
        checkOutput("repress_s_db_rise", s_db, 1'b1);

        // Glitch rejection: three high samples only
        applyStimulus(1'b0, 1'b0, n);
        waitUntil(n + 7);
        checkOutput("glitch_pre_s_db", s_db, 1'b0);
        applyStimulus(1'b1, 1'b0, n);
        waitUntil(n + 2);
        applyStimulus(1'b0, 1'b0, n2);
        for (int k = 0; k < 4; k++) begin
            waitUntil(n + 5 + 5 * k);
            checkOutput("glitch_s_db", s_db, 1'b0);
            checkOutput("glitch_conflict", conflict, 1'b0);
        end

        // Bounce then settle on reset button
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, bounce[k], n);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b1, m);
        expectPulse(m + 5, 1'b0, 1'b1, 1'b0);
        waitUntil(m + 4);
        checkOutput("bounce_r_db_early", r_db, 1'b0);
        waitUntil(m + 5);
        checkOutput("bounce_r_db_rise", r_db, 1'b1);
        checkOutput("bounce_s_db", s_db, 1'b0);
        applyStimulus(1'b0, 1'b0, n);
        waitUntil(n + 7);
        checkOutput("bounce_r_db_fall", r_db, 1'b0);

        // Simultaneous press
        applyStimulus(1'b1, 1'b1, n);
        expectPulse(n + 5, 1'b0, PRIO_R, 1'b1);
        waitUntil(n + 5);
        checkOutput("simul_s_db", s_db, 1'b1);
        checkOutput("simul_r_db", r_db, 1'b1);
        checkOutput("simul_conflict", conflict, 1'b1);
        checkOutput("simul_s", s, 1'b0);
        checkOutput("simul_r", r, PRIO_R);

        // Asynchronous reset while both levels are high
        waitUntil(n + 6);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_s_db", s_db, 1'b0);
        checkOutput("async_r_db", r_db, 1'b0);
        checkOutput("async_conflict", conflict, 1'b0);
        s_btn = 1'b0;
        r_btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-count
        applyStimulus(1'b1, 1'b0, n);
        waitUntil(n + 3);
        #2 rst = 1'b1;
        #1;
        checkOutput("midcount_s_db", s_db, 1'b0);
        checkOutput("midcount_s", s, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        expectPulse(n + 10, 1'b1, 1'b0, 1'b0);
        waitUntil(n + 9);
        checkOutput("midcount_s_db_early", s_db, 1'b0);
        waitUntil(n + 10);
        checkOutput("midcount_s_db_rise", s_db, 1'b1);

        applyStimulus(1'b0, 1'b0, n);
        waitUntil(n + 10);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending pulses, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sr_pulse_gen.md
Name: sr_pulse_gen

Overview:
- Input conditioning stage that sits directly upstream of sr_latch.
- Takes two raw, asynchronous push-button inputs and produces clean, single-cycle set and reset pulses that drive the latch's s and r inputs.
- Each channel has its own 2-flop synchroniser and counter-based debouncer; a small arbiter guarantees s and r are never high together.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronised input must differ from the stable level before the change is accepted. Legal range 2..65535.
- CW, $clog2(DEBOUNCE_CYCLES): counter width. Derived; never overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_btn  input  1  raw set button; asynchronous to clk.
- r_btn  input  1  raw reset button; asynchronous to clk.
- s  output  1  single-cycle set pulse to sr_latch.s.
- r  output  1  single-cycle reset pulse to sr_latch.r.
- s_db  output  1  debounced set-button level.
- r_db  output  1  debounced reset-button level.
- conflict  output  1  one-cycle flag: set and reset edges were accepted on the same cycle.

Behaviour:
- Reset: while rst is high, all of the following are held at 0: s, r, s_db, r_db, conflict, both synchroniser flops, both counters. Reset takes effect immediately, without waiting for clk.
- Reset mid-count: a pending count is discarded. After rst is released, debouncing restarts from level 0.
- Per-channel pipeline, shown for set; reset is identical:
  - sync1 <= s_btn, then sync2 <= sync1.
  - If sync2 == s_db: counter <= 0.
  - If sync2 != s_db and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If sync2 != s_db and counter == DEBOUNCE_CYCLES-1: s_db <= sync2 and counter <= 0.
- Latency: s_btn first sampled high at edge N, held steady → s_db rises at edge N+1+DEBOUNCE_CYCLES.
- Glitch rejection: any sync2 excursion shorter than DEBOUNCE_CYCLES cycles clears the counter. s_db does not change.
- Pulse generation:
  - Registered rise detect: s_rise = 1 in exactly the cycle in which s_db has just gone 0→1. r_rise is the same for r_db.
  - Falling edges of s_db or r_db produce no pulse.
  - Holding a button produces one pulse only.
- Arbitration:
  - s_rise only → s=1 for one cycle.
  - r_rise only → r=1 for one cycle.
  - Both on the same cycle → s=0, r=0, conflict=1 for one cycle. Default: both suppressed.
  - s and r are never 1 on the same cycle under any condition.
- Channels are fully independent apart from the arbitration.
- Counters never wrap: they saturate at DEBOUNCE_CYCLES-1 and are cleared as described above.

Optional Feature:
- Macro: SR_RESET_PRIORITY_EN.
- Defined: on simultaneous s_rise and r_rise, output r=1, s=0, conflict=1. Reset wins, so a simultaneous press leaves the latch cleared.
- Undefined: both pulses are suppressed, s=r=0, conflict=1, as in Behaviour.
- Everything else is identical with or without the macro.

Test Plan:
- Reset mid-count: DEBOUNCE_CYCLES=4, s_btn=1 from edge 0, rst pulsed high between edges 3 and 4. Required: all outputs 0 immediately on rst. After release, s_db rises 1+4 edges after the first sample taken with rst low.
- Clean set: DEBOUNCE_CYCLES=4, rst released, s_btn=1 sampled at edge 0 and held. Required: s_db=1 and s=1 after edge 5; s=0 after edge 6; s_db stays 1; r=0 and conflict=0 throughout.
- Glitch reject: s_btn high for 3 cycles then low, DEBOUNCE_CYCLES=4. Required: s_db, s and conflict remain 0 for the next 20 cycles.
- Bounce then settle: r_btn toggling 1,0,1,1,0 then held 1. Required: exactly one r pulse, 5 cycles after the start of the steady 1 (sync delay plus 4). No s pulse.
- Simultaneous press: s_btn and r_btn rise on the same edge. Required without the macro: conflict=1 for one cycle, s=r=0, s_db=r_db=1. Required with SR_RESET_PRIORITY_EN defined: r=1, s=0, conflict=1 for one cycle.
- Release and repress: s_btn released for ≥6 cycles, then pressed again. Required: s_db falls with no pulse; the repress yields exactly one fresh s pulse with the same latency as the clean set.
